// File: rtl/rr_arb_encoder.sv
// rr_arb_encoder
//
// Round-robin arbiter whose grant is presented as a registered binary index
// for a downstream decoder. While idle, the block picks the first active
// requester at or above the rotating pointer, wrapping past the top. It then
// holds that grant until the owner signals completion. The next search starts
// just above the requester that last held the grant.
//
// Parameters
//   NUM_REQ        number of requesters (2..32)
//   INDEX_WIDTH    width of grant_index, at least $clog2(NUM_REQ)
//   TIMEOUT_CYCLES maximum GRANT cycles before a forced release (1..65535),
//                  used only when RR_ARB_TIMEOUT_EN is defined
//
// Build option
//   RR_ARB_TIMEOUT_EN  when defined, adds a hold counter. A grant that has not
//                      been released is forced off after TIMEOUT_CYCLES, and
//                      timeout pulses for that one cycle. When undefined, the
//                      hold counter is absent and timeout is tied low. The
//                      port list is the same in both builds.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   req            request vector, bit i = requester i wants the resource
//   release_grant  granted requester is done; only looked at in GRANT
//   grant_valid    registered, grant_index is meaningful
//   grant_index    registered binary index of the granted requester
//   timeout        registered one-cycle pulse on a forced release
module rr_arb_encoder #(
    parameter int NUM_REQ        = 8,
    parameter int INDEX_WIDTH    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic                   release_grant,
    output logic                   grant_valid,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic                   timeout
);

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 32) begin : g_bad_num_req
        $error("rr_arb_encoder: NUM_REQ must be in 2..32");
    end
    if (INDEX_WIDTH < $clog2(NUM_REQ)) begin : g_bad_index_width
        $error("rr_arb_encoder: INDEX_WIDTH too narrow for NUM_REQ");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("rr_arb_encoder: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [INDEX_WIDTH-1:0] grant_index_q, grant_index_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

    logic                   force_release;
    logic                   found;
    logic [INDEX_WIDTH-1:0] sel_index;
    logic [2*NUM_REQ-1:0]   req_shift;
    int                     offset;
    int                     sel_pos;

    // Shifting two concatenated copies of req right by ptr yields a vector
    // whose bit k is req[(ptr + k) mod NUM_REQ]. Because ptr is always below
    // NUM_REQ, the lowest set bit of the bottom half is the circular-first
    // requester. This works without a power-of-two NUM_REQ.
    assign req_shift = {req, req} >> ptr_q;

    always_comb begin
        found     = 1'b0;
        offset    = 0;
        sel_pos   = 0;
        sel_index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_shift[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end
        sel_pos = int'(ptr_q) + offset;
        if (sel_pos >= NUM_REQ) begin
            sel_pos = sel_pos - NUM_REQ;
        end
        sel_index = INDEX_WIDTH'(sel_pos);
    end

    // The FSM next state. A grant ends on release_grant or on a forced
    // release. The pointer then moves to just above the finished grant,
    // wrapping to 0 from the top requester.
    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_index_d = grant_index_q;
        ptr_d         = ptr_q;
        unique case (state_q)
            IDLE: begin
                grant_valid_d = 1'b0;
                if (found) begin
                    state_d       = GRANT;
                    grant_valid_d = 1'b1;
                    grant_index_d = sel_index;
                end
            end
            GRANT: begin
                if (release_grant || force_release) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    if (grant_index_q == INDEX_WIDTH'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_index_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
            ptr_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
            ptr_q         <= ptr_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        timeout_q, timeout_d;

    // The counter holds the number of completed GRANT cycles, so it is 0 in
    // the first GRANT cycle. The release is forced on the TIMEOUT_CYCLES-th
    // GRANT cycle. A genuine release in that same cycle takes priority and
    // suppresses the timeout pulse.
    always_comb begin
        hold_cnt_d    = '0;
        force_release = 1'b0;
        timeout_d     = 1'b0;
        if (state_q == GRANT) begin
            hold_cnt_d    = hold_cnt_q + 16'd1;
            force_release = (hold_cnt_q == 16'(TIMEOUT_CYCLES - 1));
            timeout_d     = force_release && !release_grant;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_release = 1'b0;
    assign timeout       = 1'b0;
`endif

    assign grant_valid = grant_valid_q;
    assign grant_index = grant_index_q;

endmodule

// File: tb/tb_rr_arb_encoder.sv
// tb_rr_arb_encoder
//
// Directed bench for rr_arb_encoder. It uses an 8-requester instance with
// TIMEOUT_CYCLES=16 and a 5-requester instance for the non-power-of-two wrap
// case. Expected values are hand-derived constants. Build with or without
// RR_ARB_TIMEOUT_EN, and the expected hold/timeout behaviour follows.
module tb_rr_arb_encoder;

    logic       clk;
    logic       reset_n;

    logic [7:0] req8;
    logic       rel8;
    logic       gv8;
    logic [2:0] gi8;
    logic       to8;

    logic [4:0] req5;
    logic       rel5;
    logic       gv5;
    logic [2:0] gi5;
    logic       to5;

    int errors = 0;
    int checks = 0;

`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_BUILD = 1'b1;
`else
    localparam bit TIMEOUT_BUILD = 1'b0;
`endif

    rr_arb_encoder #(
        .NUM_REQ        (8),
        .INDEX_WIDTH    (3),
        .TIMEOUT_CYCLES (16)
    ) dut8 (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req8),
        .release_grant (rel8),
        .grant_valid   (gv8),
        .grant_index   (gi8),
        .timeout       (to8)
    );

    rr_arb_encoder #(
        .NUM_REQ        (5),
        .INDEX_WIDTH    (3),
        .TIMEOUT_CYCLES (16)
    ) dut5 (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req5),
        .release_grant (rel5),
        .grant_valid   (gv5),
        .grant_index   (gi5),
        .timeout       (to5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkGrant8(input string tag, input logic exp_gv,
                               input logic [2:0] exp_gi, input logic exp_to);
        checkOutput({tag, ".valid"},   {31'd0, gv8}, {31'd0, exp_gv});
        checkOutput({tag, ".index"},   {29'd0, gi8}, {29'd0, exp_gi});
        checkOutput({tag, ".timeout"}, {31'd0, to8}, {31'd0, exp_to});
    endtask

    // Drive both instances, then sample 1 ns after the next rising edge.
    task automatic applyStimulus(input logic [7:0] r8, input logic rl8,
                                 input logic [4:0] r5, input logic rl5);
        req8 = r8;
        rel8 = rl8;
        req5 = r5;
        rel5 = rl5;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_gv;
        logic exp_to;

        reset_n = 1'b1;
        req8    = '0;
        rel8    = 1'b0;
        req5    = '0;
        rel5    = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkGrant8("reset", 1'b0, 3'd0, 1'b0);
        checkOutput("reset.ptr8", {29'd0, dut8.ptr_q}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic arbitration from requester 0, idle gap, then requester 2.
        applyStimulus(8'b0000_0101, 1'b0, 5'd0, 1'b0);
        checkGrant8("first", 1'b1, 3'd0, 1'b0);
        applyStimulus(8'b0000_0101, 1'b1, 5'd0, 1'b0);
        checkGrant8("gap", 1'b0, 3'd0, 1'b0);
        applyStimulus(8'b0000_0101, 1'b0, 5'd0, 1'b0);
        checkGrant8("second", 1'b1, 3'd2, 1'b0);

        // Release, idle with no requests, and ignored release in IDLE.
        applyStimulus(8'h00, 1'b1, 5'd0, 1'b0);
        checkGrant8("rel2", 1'b0, 3'd2, 1'b0);
        applyStimulus(8'h00, 1'b0, 5'd0, 1'b0);
        checkGrant8("idle", 1'b0, 3'd2, 1'b0);
        applyStimulus(8'h00, 1'b1, 5'd0, 1'b0);
        checkGrant8("idle_rel", 1'b0, 3'd2, 1'b0);
        checkOutput("idle_rel.ptr8", {29'd0, dut8.ptr_q}, 32'd3);

        // Wrap: grant 7, then 0 and 7 alternate.
        applyStimulus(8'b1000_0000, 1'b0, 5'd0, 1'b0);
        checkGrant8("get7", 1'b1, 3'd7, 1'b0);
        applyStimulus(8'b1000_0001, 1'b1, 5'd0, 1'b0);
        checkGrant8("rel7", 1'b0, 3'd7, 1'b0);
        checkOutput("rel7.ptr8", {29'd0, dut8.ptr_q}, 32'd0);
        applyStimulus(8'b1000_0001, 1'b0, 5'd0, 1'b0);
        checkGrant8("wrap0", 1'b1, 3'd0, 1'b0);
        applyStimulus(8'b1000_0001, 1'b1, 5'd0, 1'b0);
        checkGrant8("rel0", 1'b0, 3'd0, 1'b0);
        applyStimulus(8'b1000_0001, 1'b0, 5'd0, 1'b0);
        checkGrant8("wrap7", 1'b1, 3'd7, 1'b0);

        // Grant 3, drop its request, and hold release low for 20 cycles.
        applyStimulus(8'b0000_1000, 1'b1, 5'd0, 1'b0);
        checkGrant8("rel7b", 1'b0, 3'd7, 1'b0);
        applyStimulus(8'b0000_1000, 1'b0, 5'd0, 1'b0);
        checkGrant8("get3", 1'b1, 3'd3, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(8'h00, 1'b0, 5'd0, 1'b0);
            exp_gv = TIMEOUT_BUILD ? (i < 16) : 1'b1;
            exp_to = TIMEOUT_BUILD && (i == 16);
            checkGrant8($sformatf("hold%0d", i), exp_gv, 3'd3, exp_to);
        end
        applyStimulus(8'h00, 1'b1, 5'd0, 1'b0);
        checkGrant8("rel3", 1'b0, 3'd3, 1'b0);
        checkOutput("rel3.ptr8", {29'd0, dut8.ptr_q}, 32'd4);

        // Release coincides with the 16th GRANT cycle: no timeout pulse.
        applyStimulus(8'b0000_0010, 1'b0, 5'd0, 1'b0);
        checkGrant8("get1", 1'b1, 3'd1, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(8'h00, 1'b0, 5'd0, 1'b0);
            checkGrant8($sformatf("keep%0d", i), 1'b1, 3'd1, 1'b0);
        end
        applyStimulus(8'h00, 1'b1, 5'd0, 1'b0);
        checkGrant8("coincide", 1'b0, 3'd1, 1'b0);
        applyStimulus(8'h00, 1'b0, 5'd0, 1'b0);
        checkGrant8("coincide_after", 1'b0, 3'd1, 1'b0);

        // Asynchronous reset mid-grant, then priority restarts at 0.
        applyStimulus(8'b0001_0000, 1'b0, 5'd0, 1'b0);
        checkGrant8("get4", 1'b1, 3'd4, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        checkGrant8("async_rst", 1'b0, 3'd0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 5'd0, 1'b0);
        checkGrant8("in_rst", 1'b0, 3'd0, 1'b0);
        reset_n = 1'b1;
        applyStimulus(8'hFF, 1'b0, 5'd0, 1'b0);
        checkGrant8("post_rst", 1'b1, 3'd0, 1'b0);
        applyStimulus(8'h00, 1'b1, 5'd0, 1'b0);
        checkGrant8("post_rst_rel", 1'b0, 3'd0, 1'b0);

        // Non-power-of-two instance: grant 4 wraps the pointer to 0, never 5.
        applyStimulus(8'h00, 1'b0, 5'b10000, 1'b0);
        checkOutput("n5.get4.valid", {31'd0, gv5}, 32'd1);
        checkOutput("n5.get4.index", {29'd0, gi5}, 32'd4);
        checkOutput("n5.get4.ptr",   {29'd0, dut5.ptr_q}, 32'd0);
        applyStimulus(8'h00, 1'b0, 5'b10010, 1'b1);
        checkOutput("n5.rel4.valid", {31'd0, gv5}, 32'd0);
        checkOutput("n5.rel4.ptr",   {29'd0, dut5.ptr_q}, 32'd0);
        applyStimulus(8'h00, 1'b0, 5'b10010, 1'b0);
        checkOutput("n5.get1.valid", {31'd0, gv5}, 32'd1);
        checkOutput("n5.get1.index", {29'd0, gi5}, 32'd1);
        checkOutput("n5.get1.ptr",   {29'd0, dut5.ptr_q}, 32'd0);
        applyStimulus(8'h00, 1'b0, 5'b00000, 1'b1);
        checkOutput("n5.rel1.valid", {31'd0, gv5}, 32'd0);
        checkOutput("n5.rel1.ptr",   {29'd0, dut5.ptr_q}, 32'd2);
        checkOutput("n5.timeout",    {31'd0, to5}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arb_encoder.md
RR_ARB_ENCODER -- requirements
Module: rr_arb_encoder

Interface
REQ-001 SHALL have parameter NUM_REQ, default 8: number of requesters, legal range 2..32.
REQ-002 SHALL have parameter INDEX_WIDTH, default 3: grant index width, ceil(log2(NUM_REQ)) or wider.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles a grant is held, used only when REQ-026 applies; legal range 1..65535.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, NUM_REQ: bit i high means requester i wants the shared resource.
REQ-007 SHALL have port release, input, 1: the granted requester is done; sampled only in GRANT.
REQ-008 SHALL have port grant_valid, output, 1: registered; grant_index is meaningful.
REQ-009 SHALL have port grant_index, output, INDEX_WIDTH: registered binary index of the granted requester, which feeds the downstream binary decoder.
REQ-010 SHALL have port timeout, output, 1: registered one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-012 In IDLE with req nonzero, SHALL select the first set req bit searching circularly upward from pointer ptr, load grant_index, set grant_valid and enter GRANT at the next edge.
REQ-013 Latency SHALL be exactly one cycle: req sampled high at edge N gives grant_valid high after edge N.
REQ-014 In IDLE with req zero, SHALL keep grant_valid low and leave grant_index and ptr unchanged.
REQ-015 In GRANT, SHALL hold grant_index and grant_valid stable regardless of req, including deassertion of the granted bit.
REQ-016 In GRANT with release high, SHALL clear grant_valid, set ptr to grant_index+1 and enter IDLE at the next edge.
REQ-017 Pointer wrap: grant_index equal to NUM_REQ-1 SHALL set ptr to 0; ptr SHALL never hold a value of NUM_REQ or more, including for non-power-of-two NUM_REQ.
REQ-018 release in IDLE SHALL be ignored.
REQ-019 Back-to-back grants SHALL be separated by exactly one cycle with grant_valid low.
REQ-020 req bits at index NUM_REQ or above do not exist; search arithmetic SHALL be performed modulo NUM_REQ.
REQ-021 With release and a forced release (REQ-026) in the same cycle, SHALL perform one release and SHALL NOT pulse timeout.

Reset
REQ-022 Asserting reset_n low SHALL immediately, without waiting for clk, set the FSM to IDLE, grant_valid to 0, grant_index to 0, ptr to 0, timeout to 0 and the hold counter to 0.
REQ-023 Reset asserted mid-grant SHALL abort the grant with no timeout pulse.
REQ-024 After reset_n deasserts, the first arbitration SHALL give requester 0 highest priority.
REQ-025 SHALL accept no requests while reset_n is low.

Configuration
REQ-026 With macro RR_ARB_TIMEOUT_EN defined, a hold counter SHALL clear on entry to GRANT and increment each GRANT cycle; when it reaches TIMEOUT_CYCLES with release low, the block SHALL behave as if release were high and pulse timeout for one cycle at the same edge that clears grant_valid.
REQ-027 Without RR_ARB_TIMEOUT_EN, there SHALL be no hold counter, grants SHALL be held until release, and timeout SHALL be tied to 0; the port list SHALL be identical in both builds.

Verification
REQ-028 Bench SHALL check, after reset, req=8'b0000_0101 -> grant_index=0 one cycle later; after release, an idle cycle, then grant_index=2.
REQ-029 Bench SHALL check wrap: last grant 7, req=8'b1000_0001 -> next grant_index=0, then 7.
REQ-030 Bench SHALL check, with NUM_REQ=5 and INDEX_WIDTH=3 and last grant 4, req=5'b10010 -> grant_index=1 and ptr never equal to 5.
REQ-031 Bench SHALL check that dropping req[3] while 3 is granted, with release held low for 20 cycles, leaves grant_index=3 and grant_valid=1 throughout (timeout disabled).
REQ-032 Bench SHALL check, with RR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, a grant held without release -> timeout pulses once and grant_valid falls after 16 GRANT cycles; with release also high that cycle -> no timeout pulse.
REQ-033 Bench SHALL check that reset_n pulsed low mid-cycle during a grant drops grant_valid to 0 before the next clk edge, leaves timeout at 0, and then req=8'hFF -> grant_index=0.
